// File: rtl/mmio_ctrl.sv
// mmio_ctrl: splits core data accesses between the data cache and a small
// I/O register file (UART TX FIFO, UART RX holding register, cycle and
// retired-instruction counters). I/O read data is registered so it lines up
// with the one-cycle synchronous read latency of the data cache.
module mmio_ctrl #(
    parameter int          TX_DEPTH  = 4,     // power of 2, >= 2
    parameter logic [3:0]  IO_REGION = 4'h8   // cpu_addr[31:28] of I/O space
) (
    input  logic        clk,
    input  logic        reset,
    // core data port
    input  logic [31:0] cpu_addr,
    input  logic [3:0]  cpu_we,
    input  logic        cpu_re,
    input  logic [31:0] cpu_din,
    output logic [31:0] cpu_dout,
    input  logic        stall,
    input  logic        inst_retire,
    // data cache
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_we,
    output logic        mem_re,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout,
    // UART transmitter
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    // UART receiver
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready
);

    localparam int PW = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(TX_DEPTH);

    // register offsets within the I/O region
    localparam logic [7:0] OFF_STATUS = 8'h00;
    localparam logic [7:0] OFF_RXDATA = 8'h04;
    localparam logic [7:0] OFF_TXDATA = 8'h08;
    localparam logic [7:0] OFF_CYCLE  = 8'h10;
    localparam logic [7:0] OFF_INST   = 8'h14;
    localparam logic [7:0] OFF_CNTCLR = 8'h18;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic          sel_q,     sel_d;
    logic [31:0]   rdata_q,   rdata_d;
    logic [CW-1:0] cnt_q,     cnt_d;
    logic [PW-1:0] rptr_q,    rptr_d;
    logic [PW-1:0] wptr_q,    wptr_d;
    logic          tx_ovf_q,  tx_ovf_d;
    logic          rx_full_q, rx_full_d;
    logic [7:0]    rx_byte_q, rx_byte_d;
    logic [31:0]   cyc_q,     cyc_d;
    logic [31:0]   inst_q,    inst_d;
    logic [7:0]    tx_mem_q [TX_DEPTH];

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic       io;
    logic [7:0] off;
    logic       io_wr, io_rd;
    logic       tx_full;
    logic       push, push_ok, pop;
    logic       rx_take, rx_clr, cnt_clr;
    logic [31:0] rd_val;

    assign io      = (cpu_addr[31:28] == IO_REGION);
    assign off     = cpu_addr[7:0];
    assign io_wr   = (|cpu_we) & io & ~stall;
    assign io_rd   = cpu_re & io & ~stall;

    assign tx_full = (cnt_q == FULL_CNT);
    assign push    = io_wr & (off == OFF_TXDATA);
    // full is judged on pre-edge state, so a same-cycle pop never makes room
    assign push_ok = push & ~tx_full;
    assign pop     = tx_valid & tx_ready;

    assign rx_take = rx_valid & rx_ready;
    assign rx_clr  = io_rd & (off == OFF_RXDATA);
    assign cnt_clr = io_wr & (off == OFF_CNTCLR);

    // ------------------------------------------------------------------
    // Pass-through and external outputs
    // ------------------------------------------------------------------
    assign mem_addr = cpu_addr;
    assign mem_din  = cpu_din;
    assign mem_we   = io ? 4'b0000 : cpu_we;
    assign mem_re   = cpu_re & ~io;

    assign tx_valid = (cnt_q != '0);
    assign tx_data  = tx_mem_q[rptr_q];
    assign rx_ready = ~rx_full_q;
    assign cpu_dout = sel_q ? rdata_q : mem_dout;

    // I/O read mux on pre-edge register values
    always_comb begin
        rd_val = 32'h0;
        unique case (off)
            OFF_STATUS: rd_val = {29'b0, tx_ovf_q, rx_full_q, ~tx_full};
            OFF_RXDATA: rd_val = {24'b0, rx_byte_q};
            OFF_CYCLE:  rd_val = cyc_q;
            OFF_INST:   rd_val = inst_q;
            default:    rd_val = 32'h0;
        endcase
    end

    // Next-state for read path, TX FIFO control, RX holding reg, counters
    always_comb begin
        sel_d     = sel_q;
        rdata_d   = rdata_q;
        cnt_d     = cnt_q;
        rptr_d    = rptr_q;
        wptr_d    = wptr_q;
        tx_ovf_d  = tx_ovf_q;
        rx_full_d = rx_full_q;
        rx_byte_d = rx_byte_q;
        cyc_d     = cyc_q + 32'd1;
        inst_d    = inst_q + {31'b0, inst_retire & ~stall};

        // read path only advances on unstalled loads
        if (cpu_re && !stall) begin
            sel_d   = io;
            rdata_d = rd_val;
        end

        // TX FIFO pointers and occupancy
        if (push_ok) wptr_d = wptr_q + PW'(1);
        if (pop)     rptr_d = rptr_q + PW'(1);
        if (push_ok && !pop)      cnt_d = cnt_q + CW'(1);
        else if (!push_ok && pop) cnt_d = cnt_q - CW'(1);

        // overflow is sticky until software writes the status register
        if (push && tx_full)                     tx_ovf_d = 1'b1;
        else if (io_wr && (off == OFF_STATUS))   tx_ovf_d = 1'b0;

        // a take can only happen while empty, a clear only matters while full
        if (rx_take) begin
            rx_full_d = 1'b1;
            rx_byte_d = rx_data;
        end else if (rx_clr) begin
            rx_full_d = 1'b0;
        end

        if (cnt_clr) begin
            cyc_d  = 32'h0;
            inst_d = 32'h0;
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_q     <= 1'b0;
            rdata_q   <= 32'h0;
            cnt_q     <= '0;
            rptr_q    <= '0;
            wptr_q    <= '0;
            tx_ovf_q  <= 1'b0;
            rx_full_q <= 1'b0;
            rx_byte_q <= 8'h0;
            cyc_q     <= 32'h0;
            inst_q    <= 32'h0;
        end else begin
            sel_q     <= sel_d;
            rdata_q   <= rdata_d;
            cnt_q     <= cnt_d;
            rptr_q    <= rptr_d;
            wptr_q    <= wptr_d;
            tx_ovf_q  <= tx_ovf_d;
            rx_full_q <= rx_full_d;
            rx_byte_q <= rx_byte_d;
            cyc_q     <= cyc_d;
            inst_q    <= inst_d;
        end
    end

    // FIFO storage; contents are don't-care until counted in, so no reset
    always_ff @(posedge clk) begin
        if (push_ok) tx_mem_q[wptr_q] <= cpu_din[7:0];
    end

endmodule
